// File: rtl/imu_pkg.sv
// Shared types and register-map constants for the IMU read path.
// The frame sequencer and any future IMU blocks import this package.
package imu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam int         WORD_W       = 16;

    // Register addresses wrap modulo 256, matching the IMU's 8-bit register space.
    function automatic logic [7:0] reg_addr(input logic [7:0] base, input int idx, input int step);
        return base + 8'(idx * step);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge pulse generator.
// Intended for any asynchronous IMU pin; o_rise is one clk wide.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/imu_read_sequencer.sv
// Reads N_WORDS consecutive IMU registers after each data-ready interrupt
// and publishes them as one atomic frame, flagging overruns and bus stalls.
module imu_read_sequencer
    import imu_pkg::*;
#(
    parameter int         N_WORDS     = 6,
    parameter logic [7:0] BASE_ADDR   = ACCEL_XOUT_H,
    parameter int         ADDR_STEP   = 2,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_err,
    input  logic                      data_ready,
    output logic                      xfer_req,
    output logic [7:0]                xfer_addr,
    input  logic                      xfer_ack,
    input  logic                      xfer_done,
    input  logic [15:0]               xfer_data,
    output logic                      frame_valid,
    output logic [WORD_W*N_WORDS-1:0] frame_data,
    output logic [15:0]               frame_cnt,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    state_t                      r_state;
    state_t                      w_next;
    logic [IDX_W-1:0]            r_idx;
    logic [TIMER_W-1:0]          r_timer;
    logic                        r_cancel;
    logic [WORD_W*N_WORDS-1:0]   r_work;
    logic [WORD_W*N_WORDS-1:0]   r_frame;
    logic [WORD_W*N_WORDS-1:0]   w_work_next;
    logic [15:0]                 r_cnt;
    logic                        r_overrun;
    logic                        r_timeout;

    logic                        w_edge;
    logic                        w_last;
    logic                        w_expired;
    logic                        w_cancel;
    logic                        w_ovr_set;
    logic                        w_to_set;

    sync_edge_detect u_drdy_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (data_ready),
        .o_rise (w_edge)
    );

    assign w_last    = (r_idx == IDX_W'(N_WORDS - 1));
    assign w_expired = (r_timer == TIMER_W'(TIMEOUT_CYC - 1));
    // A frame cancelled by en going low still drains its outstanding transfer.
    assign w_cancel  = r_cancel | ~en;
    assign w_ovr_set = w_edge && (r_state != IDLE);
    assign w_to_set  = (r_state == WAIT) && !xfer_done && w_expired;

    always_comb begin
        w_work_next = r_work;
        w_work_next[int'(r_idx)*WORD_W +: WORD_W] = xfer_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (en && w_edge) w_next = REQ;
            end
            REQ: begin
                if (xfer_ack)  w_next = WAIT;
                else if (!en)  w_next = IDLE;
            end
            WAIT: begin
                if (xfer_done) begin
                    if (w_cancel)    w_next = IDLE;
                    else if (w_last) w_next = DONE;
                    else             w_next = REQ;
                end else if (w_expired) begin
                    w_next = IDLE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The published frame and count are loaded together as the last word lands,
    // so they are already stable during the DONE cycle that pulses frame_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx    <= '0;
            r_timer  <= '0;
            r_cancel <= 1'b0;
            r_work   <= '0;
            r_frame  <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_idx    <= '0;
                    r_cancel <= 1'b0;
                end
                REQ: begin
                    r_timer  <= '0;
                    r_cancel <= ~en;
                end
                WAIT: begin
                    r_timer  <= r_timer + 1'b1;
                    r_cancel <= w_cancel;
                    if (xfer_done) begin
                        r_work <= w_work_next;
                        r_idx  <= r_idx + 1'b1;
                        if (!w_cancel && w_last) begin
                            r_frame <= w_work_next;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Setting beats clearing so an error in the clear cycle is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= w_ovr_set | (r_overrun & ~clr_err);
            r_timeout <= w_to_set  | (r_timeout & ~clr_err);
        end
    end

    assign xfer_req    = (r_state == REQ);
    assign xfer_addr   = (r_state == REQ) ? reg_addr(BASE_ADDR, int'(r_idx), ADDR_STEP) : 8'h00;
    assign frame_valid = (r_state == DONE);
    assign frame_data  = r_frame;
    assign frame_cnt   = r_cnt;
    assign busy        = (r_state != IDLE);
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_imu_read_sequencer.sv
// Randomised scoreboard bench for imu_read_sequencer with a behavioural
// transfer-engine model; expected frames are checked when frame_valid fires.
module tb_imu_read_sequencer;

    localparam int         N       = 6;
    localparam int         TMO     = 16;
    localparam logic [7:0] BASE    = 8'h3B;
    localparam int         STEP    = 2;

    typedef struct {
        logic [16*N-1:0] data;
        logic [15:0]     cnt;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            en;
    logic            clr_err;
    logic            data_ready;
    logic            xfer_req;
    logic [7:0]      xfer_addr;
    logic            xfer_ack;
    logic            xfer_done;
    logic [15:0]     xfer_data;
    logic            frame_valid;
    logic [16*N-1:0] frame_data;
    logic [15:0]     frame_cnt;
    logic            busy;
    logic            overrun;
    logic            timeout_err;

    int              nChecks = 0;
    int              nFails  = 0;
    exp_t            expQ[$];
    logic [16*N-1:0] lastFrame = '0;
    logic [15:0]     expCnt    = '0;

    imu_read_sequencer #(
        .N_WORDS     (N),
        .BASE_ADDR   (BASE),
        .ADDR_STEP   (STEP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr_err     (clr_err),
        .data_ready  (data_ready),
        .xfer_req    (xfer_req),
        .xfer_addr   (xfer_addr),
        .xfer_ack    (xfer_ack),
        .xfer_done   (xfer_done),
        .xfer_data   (xfer_data),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every frame_valid must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && frame_valid) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_frame: got frame_valid with data %0h, expected none", frame_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("frame_data", 128'(frame_data), 128'(e.data));
                checkOutput("frame_cnt", 128'(frame_cnt), 128'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReady();
        data_ready = 1'b1;
        repeat (2) step();
        data_ready = 1'b0;
    endtask

    task automatic waitReq(output bit got);
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (xfer_req) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    // One interrupt-triggered frame against the engine model; the -1 arguments disable each special case.
    task automatic applyStimulus(input int stallWord, input int tmoWord, input int ovrWord,
                                 input int cancelWord, input bit fixedData);
        logic [16*N-1:0] frame;
        logic [7:0]      expAddr;
        logic [15:0]     word;
        bit              got;
        bit              stable;
        int              ackDelay;
        int              doneDelay;
        exp_t            e;
        frame = lastFrame;
        pulseReady();
        for (int i = 0; i < N; i++) begin
            waitReq(got);
            checkOutput($sformatf("req_seen_w%0d", i), 128'(got), 128'(1));
            if (!got) return;
            expAddr = 8'((int'(BASE) + i * STEP) % 256);
            checkOutput($sformatf("addr_w%0d", i), 128'(xfer_addr), 128'(expAddr));
            ackDelay = fixedData ? 2 : int'($urandom_range(0, 4));
            if (i == stallWord) ackDelay = 50;
            stable = 1'b1;
            for (int c = 0; c < ackDelay; c++) begin
                step();
                if (!(xfer_req === 1'b1 && xfer_addr === expAddr)) stable = 1'b0;
            end
            if (i == stallWord) checkOutput("stall_hold", 128'(stable), 128'(1));
            xfer_ack = 1'b1;
            step();
            xfer_ack = 1'b0;
            checkOutput($sformatf("req_drop_w%0d", i), 128'(xfer_req), 128'(0));
            if (i == tmoWord) begin
                repeat (TMO - 1) step();
                checkOutput("timeout_early", 128'(timeout_err), 128'(0));
                step();
                checkOutput("timeout_set", 128'(timeout_err), 128'(1));
                checkOutput("timeout_idle", 128'(busy), 128'(0));
                checkOutput("timeout_frame_kept", 128'(frame_data), 128'(lastFrame));
                return;
            end
            doneDelay = fixedData ? 10 : int'($urandom_range(1, 12));
            if (i == ovrWord) doneDelay = 10;
            if (i == cancelWord) en = 1'b0;
            for (int c = 0; c < doneDelay; c++) begin
                if (i == ovrWord && c == 0) data_ready = 1'b1;
                if (i == ovrWord && c == 2) data_ready = 1'b0;
                step();
            end
            word = fixedData ? 16'(16'h1000 + i) : 16'($urandom);
            frame[i*16 +: 16] = word;
            if (i == N - 1 && i != cancelWord) begin
                expCnt   = expCnt + 16'd1;
                e.data   = frame;
                e.cnt    = expCnt;
                expQ.push_back(e);
                lastFrame = frame;
            end
            xfer_done = 1'b1;
            xfer_data = word;
            step();
            xfer_done = 1'b0;
            xfer_data = 16'h0;
            if (i == cancelWord) begin
                checkOutput("cancel_idle", 128'(busy), 128'(0));
                en = 1'b1;
                return;
            end
        end
        repeat (3) step();
        checkOutput("frame_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        bit got;
        rst        = 1'b0;
        en         = 1'b0;
        clr_err    = 1'b0;
        data_ready = 1'b0;
        xfer_ack   = 1'b0;
        xfer_done  = 1'b0;
        xfer_data  = 16'h0;
        repeat (3) step();
        checkOutput("reset_ctrl", 128'({xfer_req, xfer_addr, frame_valid, frame_cnt, busy, overrun, timeout_err}), 128'(0));
        checkOutput("reset_frame", 128'(frame_data), 128'(0));
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) step();

        $display("[TB] nominal frame");
        applyStimulus(-1, -1, -1, -1, 1'b1);

        $display("[TB] back-pressure on word 3");
        applyStimulus(3, -1, -1, -1, 1'b0);

        $display("[TB] timeout on word 2");
        applyStimulus(-1, 2, -1, -1, 1'b0);
        applyStimulus(-1, -1, -1, -1, 1'b0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checkOutput("timeout_clr", 128'(timeout_err), 128'(0));

        $display("[TB] overrun during word 4");
        applyStimulus(-1, -1, 4, -1, 1'b0);
        checkOutput("overrun_set", 128'(overrun), 128'(1));
        repeat (6) step();
        checkOutput("overrun_no_queue", 128'(busy), 128'(0));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checkOutput("overrun_clr", 128'(overrun), 128'(0));

        $display("[TB] enable control");
        en = 1'b0;
        pulseReady();
        repeat (10) step();
        checkOutput("en_low_no_req", 128'({busy, xfer_req}), 128'(0));
        en = 1'b1;
        repeat (2) step();
        pulseReady();
        waitReq(got);
        checkOutput("en_drop_req_seen", 128'(got), 128'(1));
        en = 1'b0;
        step();
        checkOutput("en_drop_req", 128'({busy, xfer_req}), 128'(0));
        en = 1'b1;
        repeat (2) step();
        applyStimulus(-1, -1, -1, 1, 1'b0);
        repeat (2) step();

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            applyStimulus(-1, -1, -1, -1, 1'b0);
        end

        $display("[TB] reset mid-frame");
        pulseReady();
        waitReq(got);
        xfer_ack = 1'b1;
        step();
        xfer_ack = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        checkOutput("midreset_ctrl", 128'({xfer_req, xfer_addr, frame_valid, frame_cnt, busy, overrun, timeout_err}), 128'(0));
        checkOutput("midreset_frame", 128'(frame_data), 128'(0));
        step();
        rst       = 1'b1;
        expCnt    = '0;
        lastFrame = '0;
        repeat (2) step();
        applyStimulus(-1, -1, -1, -1, 1'b0);

        repeat (5) step();
        checkOutput("scoreboard_empty", 128'(expQ.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
